fsm_seq_detect: RTL
===================

Name: fsm_seq_detect

Overview:
- Parametrised serial pattern-detector FSM. It is the successor to the fixed three-state Mealy/Moore example FSMs.
- Detects a LEN-bit PATTERN on a 1-bit serial input.
- Provides both a Mealy output (same cycle as the last bit) and a Moore output (cycle after).
- Selectable overlapping or non-overlapping detection. Used as the reusable detector in later lab designs.

Parameters:
- LEN, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1011: LEN-bit pattern; MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = restart from empty after a match.
- CNT_W, 8: match counter width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low (0 clears all state).
- en, input, 1: din is valid this cycle.
- din, input, 1: serial data bit.
- clr, input, 1: synchronous clear of state and counter.
- match_mealy, output, 1: combinational; pattern completes on this cycle's din.
- match_moore, output, 1: registered; FSM currently sits in the full-match state.
- state_o, output, SW = $clog2(LEN+1): current state (matched-prefix length).
- match_cnt, output, CNT_W: saturating match count (only with MATCH_CNT_EN).

Behaviour:
- Reset (reset=0, asynchronous): state=0, match_moore=0, match_cnt=0. match_mealy=0 whenever reset=0.
- State k (0..LEN) = number of PATTERN bits currently matched. State LEN is the Moore match state.
- Transition table: next(k,bit) = length of the longest PATTERN prefix that is a suffix of (PATTERN[first k bits] followed by bit). This is a KMP automaton.
  - Computed at elaboration via a constant function; no runtime table loading.
  - From state LEN with OVERLAP=1: fall back through the failure function (e.g. 1011 falls back to 1).
  - From state LEN with OVERLAP=0: next(LEN,bit) = next(0,bit).
- Per rising clk, with priority clr > en:
  - clr=1: state<=0, counter<=0 (if enabled).
  - else en=1: state<=next(state,din).
  - else: state holds.
- match_mealy = en & ~clr & (next(state,din)==LEN). Combinational, zero latency.
- match_moore = (state==LEN). One cycle after match_mealy.
  - Stays high while en=0 and state==LEN.
  - Drops on the next enabled bit unless that bit also completes a match.
- Consecutive matches (overlap, PATTERN=1111): match_moore stays high across the cycles.
- Reset asserted mid-pattern: the partial match is discarded immediately, no clock needed.
- Release of reset is assumed synchronised externally.
- X on din while en=0 must not change state.

Optional Feature:
- Macro name: MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on every cycle where match_mealy=1.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset or clr; clr wins over a same-cycle increment.
- Undefined:
  - Counter register is absent.
  - match_cnt is tied to 0; the port list is unchanged.

Decomposition:
- Shared package fsm_pkg holds:
  - the SW width function;
  - the constant function building the failure/next-state table;
  - the OVERLAP mode constants (OVL_ON=1, OVL_OFF=0).
- One natural sub-module: fsm_sat_counter (CNT_W-wide saturating counter with sync clear). It is instantiated only under MATCH_CNT_EN.

Test Plan:
1. Reset: hold reset=0 for 2 clocks with random din/en -> state_o=0, match_mealy=0, match_moore=0, match_cnt=0. Assert reset mid-cycle after 3 bits -> state_o=0 before the next edge.
2. Basic match (LEN=4, PATTERN=1011): en=1, din=1,0,1,1 -> match_mealy=1 in the 4th cycle; match_moore=1 the cycle after; match_cnt=1.
3. Overlap: din=1011011. OVERLAP=1 -> match_mealy at bits 4 and 7, cnt=2. OVERLAP=0 instance -> match at bit 4 only, cnt=1, final state_o=1.
4. Enable gating: din=1,0 (en=1), then 3 cycles en=0 with din=X, then 1,1 (en=1) -> state_o holds 2 during the gap; match at the final bit.
5. clr priority: din=1,0,1, then clr=1 with en=1 and din=1 -> match_mealy=0, state_o=0, match_cnt unchanged at 0.
6. Saturation (CNT_W=2, MATCH_CNT_EN defined): 5 back-to-back overlapping matches with PATTERN=1111 -> match_cnt=1,2,3,3,3. Without the macro -> match_cnt stays 0.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the serial pattern detector: state-width helper,
// KMP next-state builder, overlap mode constants and the per-cycle action enum.
package fsm_pkg;

  localparam int OVL_OFF = 0;
  localparam int OVL_ON  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_STEP  = 2'd1,
    ACT_CLEAR = 2'd2
  } fsm_act_e;

  function automatic int sw_of(input int len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  // The pattern is MSB-first in pat[len-1:0].
  function automatic int kmp_next(input int len, input logic [15:0] pat,
                                  input int overlap, input int k, input logic b);
    int   base;
    int   best;
    int   j;
    logic ok;
    logic s_bit;
    base = (k == len && overlap == OVL_OFF) ? 0 : k;
    best = 0;
    for (int m = 1; m <= len; m++) begin
      if (m <= base + 1) begin
        ok = 1'b1;
        for (int i = 0; i < m; i++) begin
          j     = base + 1 - m + i;
          s_bit = (j == base) ? b : pat[4'(len - 1 - j)];
          if (s_bit != pat[4'(len - 1 - i)]) ok = 1'b0;
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/fsm_sat_counter.sv
// W-bit saturating up-counter with synchronous clear (clear beats increment).
module fsm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fsm_seq_detect.sv
// Parametrised KMP serial pattern detector with Mealy and Moore match outputs.
// Optional saturating match counter enabled by defining MATCH_CNT_EN.
module fsm_seq_detect
  import fsm_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = OVL_ON,
  parameter int             CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   din,
  input  logic                   clr,
  output logic                   match_mealy,
  output logic                   match_moore,
  output logic [sw_of(LEN)-1:0]  state_o,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam int             SW    = sw_of(LEN);
  localparam int             ROWS  = 1 << SW;
  localparam logic [SW-1:0]  FULL  = SW'(LEN);

  logic [SW-1:0] r_state;
  logic [SW-1:0] w_state_nxt;
  logic [SW-1:0] w_step;
  logic          w_mealy;
  fsm_act_e      w_act;
  logic [SW-1:0] w_nxt_tab [0:ROWS-1][0:1];

  // Constant transition table, padded to a power of two so r_state indexes it exactly.
  for (genvar gk = 0; gk < ROWS; gk++) begin : g_row
    for (genvar gb = 0; gb < 2; gb++) begin : g_col
      if (gk <= LEN) begin : g_live
        localparam int NX = kmp_next(LEN, 16'(PATTERN), OVERLAP, gk, 1'(gb));
        assign w_nxt_tab[gk][gb] = SW'(NX);
      end else begin : g_pad
        assign w_nxt_tab[gk][gb] = '0;
      end
    end
  end

  assign w_step = w_nxt_tab[r_state][din];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_act       = ACT_HOLD;
    w_state_nxt = r_state;
    w_mealy     = 1'b0;
    if (clr) begin
      w_act = ACT_CLEAR;
    end else if (en) begin
      w_act = ACT_STEP;
    end
    case (w_act)
      ACT_CLEAR: w_state_nxt = '0;
      ACT_STEP: begin
        w_state_nxt = w_step;
        w_mealy     = (w_step == FULL);
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign match_mealy = w_mealy & reset;
  assign match_moore = (r_state == FULL);
  assign state_o     = r_state;

`ifdef MATCH_CNT_EN
  fsm_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (clr),
    .i_inc (match_mealy),
    .o_cnt (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule
